pmt_count_combiner: RTL and testbench

Parametrised successor to the two-channel PMT count summer. It latches one time-bin of per-channel PMT counts and applies a selectable combine mode: masked sum, packed per-channel, or sum followed by packed. The result goes out as a little-endian byte stream with a valid/ready handshake and a last-byte marker. It sits between the per-channel time-bin counters and the byte-wide uplink FIFO to the PC.

---
 rtl/pmt_count_combiner.sv | 186 ++++++++++++++++++
 tb/tb_pmt_count_combiner.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmt_count_combiner.sv
// pmt_count_combiner: latches one time-bin of per-channel PMT counts and
// emits a masked sum, the packed masked channels, or both, as a
// little-endian byte stream with valid/ready handshake and last marker.
//
// Parameters:
//   CHANNELS  number of count channels (1..8)
//   CW        width of each channel count (1..16), CB = ceil(CW/8) bytes
//   SW        sum width (8..24), SB = ceil(SW/8) bytes
// Ports:
//   clock, reset         rising-edge clock, async active-high reset
//   count, count_valid   channel k at count[k*CW +: CW]; capture strobe
//   mode                 00 SUM, 01 PACK, 10 SUM_PACK, 11 SUM
//   chan_mask            1 = channel included
//   out_data/out_valid/out_ready/out_last   byte stream
//   busy                 frame in progress
//   frame_done           one-cycle pulse at frame completion
//   dropped              sticky: count_valid seen while busy
// Build option:
//   PMT_COMBINE_SATURATE_EN  defined: sum clamps at 2^SW-1; else wraps.

module pmt_count_combiner #(
    parameter int CHANNELS = 2,
    parameter int CW       = 8,
    parameter int SW       = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [CHANNELS*CW-1:0] count,
    input  logic                   count_valid,
    input  logic [1:0]             mode,
    input  logic [CHANNELS-1:0]    chan_mask,
    output logic [7:0]             out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   busy,
    output logic                   frame_done,
    output logic                   dropped
);

    localparam int CB   = (CW + 7) / 8;
    localparam int SB   = (SW + 7) / 8;
    localparam int MAXB = SB + CHANNELS * CB;
    localparam int PW   = MAXB * 8;
    localparam int NW   = $clog2(MAXB + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SUM,
        S_SEND,
        S_DONE
    } state_t;

    state_t                 state;
    logic [CHANNELS*CW-1:0] count_r;
    logic [1:0]             mode_r;
    logic [CHANNELS-1:0]    mask_r;
    logic [PW-1:0]          plan_r;
    logic [NW-1:0]          left_r;

    logic [PW-1:0]          plan_c;
    logic [NW-1:0]          n_c;
    logic [31:0]            acc;
    logic [SW-1:0]          sum_c;
    logic [SB*8-1:0]        sum_x;
    logic [CB*8-1:0]        ch_x;
    int                     pos;

    // Accumulate in 32 bits so the true sum is known before clamp/wrap.
    always_comb begin
        acc = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (mask_r[k]) begin
                acc = acc + 32'(count_r[k*CW +: CW]);
            end
        end
`ifdef PMT_COMBINE_SATURATE_EN
        if (|(acc >> SW)) begin
            sum_c = '1;
        end else begin
            sum_c = acc[SW-1:0];
        end
`else
        sum_c = acc[SW-1:0];
`endif
    end

    // Byte plan: optional sum bytes followed by optional packed channels,
    // laid out from byte 0 upward so the sender just shifts right.
    always_comb begin
        plan_c = '0;
        pos    = 0;
        sum_x  = '0;
        sum_x[SW-1:0] = sum_c;
        ch_x   = '0;
        if (mode_r != 2'b01) begin
            for (int b = 0; b < SB; b++) begin
                plan_c[pos*8 +: 8] = sum_x[b*8 +: 8];
                pos = pos + 1;
            end
        end
        if (mode_r == 2'b01 || mode_r == 2'b10) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (mask_r[k]) begin
                    ch_x = '0;
                    ch_x[CW-1:0] = count_r[k*CW +: CW];
                    for (int b = 0; b < CB; b++) begin
                        plan_c[pos*8 +: 8] = ch_x[b*8 +: 8];
                        pos = pos + 1;
                    end
                end
            end
        end
        n_c = NW'(pos);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            count_r    <= '0;
            mode_r     <= '0;
            mask_r     <= '0;
            plan_r     <= '0;
            left_r     <= '0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            if (count_valid && state != S_IDLE) begin
                dropped <= 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (count_valid) begin
                        count_r <= count;
                        mode_r  <= mode;
                        mask_r  <= chan_mask;
                        busy    <= 1'b1;
                        state   <= S_SUM;
                    end
                end
                S_SUM: begin
                    plan_r <= plan_c;
                    left_r <= n_c;
                    if (n_c == '0) begin
                        frame_done <= 1'b1;
                        state      <= S_DONE;
                    end else begin
                        out_valid <= 1'b1;
                        out_data  <= plan_c[7:0];
                        out_last  <= (n_c == NW'(1));
                        state     <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (left_r == NW'(1)) begin
                            out_valid  <= 1'b0;
                            out_last   <= 1'b0;
                            out_data   <= '0;
                            frame_done <= 1'b1;
                            state      <= S_DONE;
                        end else begin
                            plan_r   <= plan_r >> 8;
                            out_data <= plan_r[15:8];
                            left_r   <= left_r - NW'(1);
                            out_last <= (left_r == NW'(2));
                        end
                    end
                end
                S_DONE: begin
                    frame_done <= 1'b0;
                    busy       <= 1'b0;
                    state      <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pmt_count_combiner.sv
// tb_pmt_count_combiner: randomized frames on two configurations checked
// against a byte-plan model, plus literal vectors and reset/drop cases.

module tb_pmt_count_combiner;

    logic clk, rst, rdy;
    int   cyc, rmode;
    int   ncmp, nbad;

    // instance 0: defaults (2 ch, CW=8, SW=16)
    logic [15:0] cnt0;
    logic [1:0]  md0, mk0;
    logic        cv0;
    logic [7:0]  od0;
    logic        ov0, ol0, bz0, fd0, dr0;

    // instance 1: 3 ch, CW=10, SW=8
    logic [29:0] cnt1;
    logic [1:0]  md1;
    logic [2:0]  mk1;
    logic        cv1;
    logic [7:0]  od1;
    logic        ov1, ol1, bz1, fd1, dr1;

    logic [7:0] q0[$], q1[$], cap0[$], cap1[$];
    int   st0, st1, n0, n1, done0, done1;
    bit   drop0, drop1, hv0, hv1, hl0, hl1;
    logic [7:0] hd0, hd1;

    pmt_count_combiner u0 (
        .clock(clk), .reset(rst), .count(cnt0), .count_valid(cv0),
        .mode(md0), .chan_mask(mk0), .out_data(od0), .out_valid(ov0),
        .out_ready(rdy), .out_last(ol0), .busy(bz0),
        .frame_done(fd0), .dropped(dr0)
    );

    pmt_count_combiner #(.CHANNELS(3), .CW(10), .SW(8)) u1 (
        .clock(clk), .reset(rst), .count(cnt1), .count_valid(cv1),
        .mode(md1), .chan_mask(mk1), .out_data(od1), .out_valid(ov1),
        .out_ready(rdy), .out_last(ol1), .busy(bz1),
        .frame_done(fd1), .dropped(dr1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (rmode)
            0: rdy = 1'b1;
            1: rdy = ~rdy;
            2: rdy = 1'($urandom_range(0, 1));
            3: rdy = 1'b0;
            default: ;
        endcase
    end

    task automatic chk(input string nm, input int act, input int exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected byte sequence of one frame from the combine rules.
    function automatic int build(input int ch, input int cw, input int sw,
                                 input int c[8], input int md,
                                 input int msk, output logic [7:0] b[32]);
        longint s, mx;
        int n, sb, cb;
        s  = 0;
        n  = 0;
        sb = (sw + 7) / 8;
        cb = (cw + 7) / 8;
        mx = (64'd1 << sw) - 1;
        for (int i = 0; i < 32; i++) b[i] = 8'h00;
        for (int k = 0; k < ch; k++) if (msk[k]) s += c[k];
`ifdef PMT_COMBINE_SATURATE_EN
        if (s > mx) s = mx;
`else
        s = s % (mx + 1);
`endif
        if (md != 1) begin
            for (int i = 0; i < sb; i++) begin
                b[n] = 8'((s >> (8 * i)) & 255);
                n++;
            end
        end
        if (md == 1 || md == 2) begin
            for (int k = 0; k < ch; k++) begin
                if (msk[k]) begin
                    for (int i = 0; i < cb; i++) begin
                        b[n] = 8'((c[k] >> (8 * i)) & 255);
                        n++;
                    end
                end
            end
        end
        return n;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (hv0 && ov0) chk("hold0", {ol0, od0}, {hl0, hd0});
            hv0 = ov0 && !rdy;
            hl0 = ol0;
            hd0 = od0;
            if (ov0) begin
                if (q0.size() == 0) chk("extra_byte0", 1, 0);
                else begin
                    chk("data0", od0, q0[0]);
                    chk("last0", ol0, int'(q0.size() == 1));
                    if (rdy) begin
                        cap0.push_back(od0);
                        void'(q0.pop_front());
                    end
                end
            end
            if (fd0) begin
                chk("done_q0", q0.size(), 0);
                if (rmode == 0) chk("done_cyc0", cyc - st0, n0 + 2);
                done0++;
            end
            chk("dropped0", dr0, drop0);
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (hv1 && ov1) chk("hold1", {ol1, od1}, {hl1, hd1});
            hv1 = ov1 && !rdy;
            hl1 = ol1;
            hd1 = od1;
            if (ov1) begin
                if (q1.size() == 0) chk("extra_byte1", 1, 0);
                else begin
                    chk("data1", od1, q1[0]);
                    chk("last1", ol1, int'(q1.size() == 1));
                    if (rdy) begin
                        cap1.push_back(od1);
                        void'(q1.pop_front());
                    end
                end
            end
            if (fd1) begin
                chk("done_q1", q1.size(), 0);
                if (rmode == 0) chk("done_cyc1", cyc - st1, n1 + 2);
                done1++;
            end
            chk("dropped1", dr1, drop1);
        end
    end

    task automatic frame(input int sel, input int c[8], input int md,
                         input int msk, input bit drop);
        logic [7:0] b[32];
        int n, d;
        n = build(sel ? 3 : 2, sel ? 10 : 8, sel ? 8 : 16, c, md, msk, b);
        @(posedge clk);
        #1;
        if (sel == 0) begin
            cap0.delete();
            for (int i = 0; i < n; i++) q0.push_back(b[i]);
            cnt0 = {8'(c[1]), 8'(c[0])};
            md0  = 2'(md);
            mk0  = 2'(msk);
            cv0  = 1'b1;
            st0  = cyc;
            n0   = n;
            d    = done0;
        end else begin
            cap1.delete();
            for (int i = 0; i < n; i++) q1.push_back(b[i]);
            cnt1 = {10'(c[2]), 10'(c[1]), 10'(c[0])};
            md1  = 2'(md);
            mk1  = 3'(msk);
            cv1  = 1'b1;
            st1  = cyc;
            n1   = n;
            d    = done1;
        end
        @(posedge clk);
        #1;
        cv0 = 1'b0;
        cv1 = 1'b0;
        cnt0 = 16'($urandom);
        cnt1 = 30'($urandom);
        md0 = 2'($urandom);
        md1 = 2'($urandom);
        mk0 = 2'($urandom);
        mk1 = 3'($urandom);
        @(negedge clk);
        chk("busy_start", sel ? bz1 : bz0, 1);
        if (drop) begin
            @(posedge clk);
            #1;
            if (sel == 0) cv0 = 1'b1;
            else cv1 = 1'b1;
            @(posedge clk);
            #1;
            cv0 = 1'b0;
            cv1 = 1'b0;
            if (sel == 0) drop0 = 1'b1;
            else drop1 = 1'b1;
        end
        for (int t = 0; t < 400 && (sel ? done1 : done0) == d; t++)
            @(posedge clk);
        if ((sel ? done1 : done0) == d) chk("timeout", 0, 1);
        @(negedge clk);
        chk("busy_end", sel ? bz1 : bz0, 0);
    endtask

    initial begin
        logic [7:0] b[32];
        int c[8];
        int n, d;
        ncmp = 0; nbad = 0; cyc = 0; rmode = 0; rdy = 1'b1;
        done0 = 0; done1 = 0; drop0 = 0; drop1 = 0;
        hv0 = 0; hv1 = 0; st0 = 0; st1 = 0; n0 = 0; n1 = 0;
        cnt0 = '0; md0 = '0; mk0 = '0; cv0 = 1'b0;
        cnt1 = '0; md1 = '0; mk1 = '0; cv1 = 1'b0;
        rst = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("rst_data", od0, 0);
        chk("rst_valid", ov0, 0);
        chk("rst_last", ol0, 0);
        chk("rst_busy", bz0, 0);
        chk("rst_done", fd0, 0);
        chk("rst_drop", dr0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // model pinned to hand-computed bytes
        c = '{200, 100, 0, 0, 0, 0, 0, 0};
        n = build(2, 8, 16, c, 0, 3, b);
        chk("model_sum_n", n, 2);
        chk("model_sum_b0", b[0], 'h2C);
        chk("model_sum_b1", b[1], 'h01);
        c = '{5, 7, 0, 0, 0, 0, 0, 0};
        n = build(2, 8, 16, c, 2, 3, b);
        chk("model_sp_n", n, 4);
        chk("model_sp_b3", b[3], 'h07);

        // SUM 200+100
        rmode = 0;
        c = '{200, 100, 0, 0, 0, 0, 0, 0};
        frame(0, c, 0, 3, 0);
        chk("lit_sum_n", cap0.size(), 2);
        if (cap0.size() == 2) begin
            chk("lit_sum_b0", cap0[0], 'h2C);
            chk("lit_sum_b1", cap0[1], 'h01);
        end

        // PACK mask 10
        c = '{'h12, 'h34, 0, 0, 0, 0, 0, 0};
        frame(0, c, 1, 2, 0);
        chk("lit_pack_n", cap0.size(), 1);
        if (cap0.size() == 1) chk("lit_pack_b0", cap0[0], 'h34);

        // PACK mask 00: no bytes, frame_done at cycle 2
        frame(0, c, 1, 0, 0);
        chk("lit_empty_n", cap0.size(), 0);

        // SUM_PACK with toggling ready
        rmode = 1;
        c = '{5, 7, 0, 0, 0, 0, 0, 0};
        frame(0, c, 2, 3, 0);
        chk("lit_sp_n", cap0.size(), 4);
        if (cap0.size() == 4) begin
            chk("lit_sp_b0", cap0[0], 'h0C);
            chk("lit_sp_b1", cap0[1], 'h00);
            chk("lit_sp_b2", cap0[2], 'h05);
            chk("lit_sp_b3", cap0[3], 'h07);
        end

        // SW=8 overflow: 255+255
        rmode = 0;
        c = '{255, 255, 0, 0, 0, 0, 0, 0};
        frame(1, c, 0, 3, 0);
        chk("lit_ovf_n", cap1.size(), 1);
`ifdef PMT_COMBINE_SATURATE_EN
        if (cap1.size() == 1) chk("lit_ovf_b0", cap1[0], 'hFF);
`else
        if (cap1.size() == 1) chk("lit_ovf_b0", cap1[0], 'hFE);
`endif

        // capture while busy
        c = '{9, 3, 0, 0, 0, 0, 0, 0};
        frame(0, c, 2, 3, 1);

        for (int i = 0; i < 40; i++) begin
            rmode = $urandom_range(0, 2);
            for (int k = 0; k < 8; k++) c[k] = $urandom_range(0, 255);
            frame(0, c, $urandom_range(0, 3), $urandom_range(0, 3),
                  $urandom_range(0, 7) == 0);
        end
        for (int i = 0; i < 25; i++) begin
            rmode = $urandom_range(0, 2);
            for (int k = 0; k < 8; k++) c[k] = $urandom_range(0, 1023);
            frame(1, c, $urandom_range(0, 3), $urandom_range(0, 7),
                  $urandom_range(0, 7) == 0);
        end

        // reset during the second byte
        rmode = 4;
        rdy = 1'b1;
        c = '{5, 7, 0, 0, 0, 0, 0, 0};
        n = build(2, 8, 16, c, 2, 3, b);
        @(posedge clk);
        #1;
        for (int i = 0; i < n; i++) q0.push_back(b[i]);
        cnt0 = {8'd7, 8'd5};
        md0 = 2'd2;
        mk0 = 2'd3;
        cv0 = 1'b1;
        st0 = cyc;
        n0 = n;
        @(posedge clk);
        #1 cv0 = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1 rdy = 1'b0;
        #2;
        d = done0;
        rst = 1'b1;
        #1;
        chk("abort_data", od0, 0);
        chk("abort_valid", ov0, 0);
        chk("abort_last", ol0, 0);
        chk("abort_busy", bz0, 0);
        chk("abort_done", fd0, 0);
        chk("abort_drop", dr0, 0);
        q0.delete();
        hv0 = 0; hv1 = 0; drop0 = 0; drop1 = 0;
        @(posedge clk);
        #1 rst = 1'b0;
        rmode = 0;
        repeat (4) @(posedge clk);
        chk("abort_no_done", done0, d);
        c = '{40, 2, 0, 0, 0, 0, 0, 0};
        frame(0, c, 0, 1, 0);
        chk("post_rst_n", cap0.size(), 2);
        if (cap0.size() == 2) chk("post_rst_b0", cap0[0], 40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
        $finish;
    end

endmodule
